// File: rtl/lsu_pkg.sv
// LSU shared definitions: access-size encodings, FSM states, bus width.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b011,
        SZ_HU = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores, load extraction/extension, access checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]        rw_ctrl,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        ld_size,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign,
    output logic              illegal
);

    logic              is_st;
    logic              mis_raw;
    logic [DATA_W-1:0] sh;

    assign is_st = rw_ctrl[3];

    always_comb begin
        be      = '0;
        st_data = wdata;
        mis_raw = 1'b0;
        illegal = 1'b0;
        case (rw_ctrl[2:0])
            SZ_B, SZ_BU: begin
                be      = 4'b0001 << off;
                st_data = {4{wdata[7:0]}};
                illegal = is_st && (rw_ctrl[2:0] == SZ_BU);
            end
            SZ_H, SZ_HU: begin
                be      = 4'b0011 << {off[1], 1'b0};
                st_data = {2{wdata[15:0]}};
                mis_raw = off[0];
                illegal = is_st && (rw_ctrl[2:0] == SZ_HU);
            end
            SZ_W: begin
                be      = 4'b1111;
                mis_raw = (off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    // An illegal encoding is reported alone, never as misaligned too.
    assign misalign = mis_raw & ~illegal;

    assign sh = rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   ld_data = {24'b0, sh[7:0]};
            SZ_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   ld_data = {16'b0, sh[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus master: accepts one core access at a time and
// runs it as a single word-aligned memory transaction.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        rw_ctrl_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic              illegal_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] st_c;
    logic [DATA_W-1:0] ld_c;
    logic              mis_c;
    logic              ill_c;
    logic [31:0]       word_addr;

    // Upper address bits are dropped; the mask wraps to all ones at 32.
    assign word_addr = addr_i & ((32'h1 << ADDR_W) - 32'h1) & ~32'h3;

    assign req_ready_o = (state == S_IDLE);

    lsu_align u_align (
        .rw_ctrl  (rw_ctrl_i),
        .off      (addr_i[1:0]),
        .wdata    (wdata_i),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .rdata    (mem_rdata_i),
        .be       (be_c),
        .st_data  (st_c),
        .ld_data  (ld_c),
        .misalign (mis_c),
        .illegal  (ill_c)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            size_q      <= '0;
            off_q       <= '0;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            misalign_o  <= 1'b0;
            illegal_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        size_q <= rw_ctrl_i[2:0];
                        off_q  <= addr_i[1:0];
                        if (ill_c || mis_c) begin
                            illegal_o   <= ill_c;
                            misalign_o  <= mis_c;
                            rsp_valid_o <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= rw_ctrl_i[3];
                            mem_be_o    <= be_c;
                            mem_addr_o  <= word_addr[ADDR_W-1:0];
                            mem_wdata_o <= st_c;
                            state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o   <= 1'b0;
                        rsp_valid_o <= mem_we_o;
                        state       <= mem_we_o ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_o     <= ld_c;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_o <= 1'b0;
                    misalign_o  <= 1'b0;
                    illegal_o   <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus with hand-computed expectations.
module tb_lsu_bus;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  rw_ctrl_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        illegal_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_bus dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .rw_ctrl_i    (rw_ctrl_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rdata_o      (rdata_o),
        .misalign_o   (misalign_o),
        .illegal_o    (illegal_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Store with immediate grant; checks bus phase and the response cycle.
    task automatic do_store(input string tag, input logic [3:0] rw,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] ea);
        req_valid_i = 1'b1; rw_ctrl_i = rw; addr_i = a; wdata_i = wd;
        mem_gnt_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd1);
        chk({tag, "_be"}, 32'(mem_be_o), 32'(ebe));
        chk({tag, "_wd"}, mem_wdata_o, ewd);
        chk({tag, "_addr"}, 32'(mem_addr_o), ea);
        chk({tag, "_rsp_early"}, 32'(rsp_valid_o), 32'd0);
        tick();
        mem_gnt_i = 1'b0;
        chk({tag, "_rsp"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_err"}, {30'b0, misalign_o, illegal_o}, 32'd0);
        chk({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
        tick();
        chk({tag, "_rsp_end"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    // Load: grant in first REQ cycle, rvalid the cycle after.
    task automatic do_load(input string tag, input logic [3:0] rw,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [3:0] ebe, input logic [31:0] ea,
                           input logic [31:0] erd);
        req_valid_i = 1'b1; rw_ctrl_i = rw; addr_i = a;
        mem_gnt_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_be"}, 32'(mem_be_o), 32'(ebe));
        chk({tag, "_addr"}, 32'(mem_addr_o), ea);
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
        chk({tag, "_wait_rsp"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_wait_req"}, 32'(mem_req_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        chk({tag, "_rsp"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_rdata"}, rdata_o, erd);
        tick();
        chk({tag, "_rsp_end"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_hold"}, rdata_o, erd);
    endtask

    // Aborted access: response next cycle, no memory request.
    task automatic do_err(input string tag, input logic [3:0] rw,
                          input logic [31:0] a, input logic emis,
                          input logic eill);
        req_valid_i = 1'b1; rw_ctrl_i = rw; addr_i = a;
        tick();
        req_valid_i = 1'b0;
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_rsp"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_mis"}, 32'(misalign_o), 32'(emis));
        chk({tag, "_ill"}, 32'(illegal_o), 32'(eill));
        tick();
        chk({tag, "_rsp_end"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_flags_end"}, {30'b0, misalign_o, illegal_o}, 32'd0);
        chk({tag, "_req_after"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rstn_i = 1'b0; req_valid_i = 1'b0; rw_ctrl_i = 4'h0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rst_flags", {30'b0, misalign_o, illegal_o}, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        rstn_i = 1'b1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);

        do_store("sb3", 4'b1000, 32'h003, 32'h000000A5,
                 4'b1000, 32'hA5A5A5A5, 32'h000);
        do_store("sh_a", 4'b1001, 32'h00A, 32'hDEAD1234,
                 4'b1100, 32'h12341234, 32'h008);
        do_store("sw_hi", 4'b1010, 32'hFFFFF00C, 32'h01234567,
                 4'b1111, 32'h01234567, 32'h00C);
        do_load("lb", 4'b0000, 32'h102, 32'h00807F00,
                4'b0100, 32'h100, 32'hFFFFFF80);
        do_load("lbu", 4'b0011, 32'h102, 32'h00807F00,
                4'b0100, 32'h100, 32'h00000080);
        do_load("lh2", 4'b0001, 32'h002, 32'h80010000,
                4'b1100, 32'h000, 32'hFFFF8001);
        do_load("lb1", 4'b0000, 32'h041, 32'h00007F00,
                4'b0010, 32'h040, 32'h0000007F);

        do_err("lh_mis", 4'b0001, 32'h101, 1'b1, 1'b0);
        do_err("sbu_ill", 4'b1011, 32'h000, 1'b0, 1'b1);
        do_err("lw_mis", 4'b0010, 32'h002, 1'b1, 1'b0);
        do_err("ill_pri", 4'b0110, 32'h003, 1'b0, 1'b1);
        do_err("shu_ill", 4'b1100, 32'h001, 1'b0, 1'b1);

        // Grant stall: request and address must hold.
        req_valid_i = 1'b1; rw_ctrl_i = 4'b0010; addr_i = 32'h0F8;
        mem_gnt_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(mem_req_o), 32'd1);
            chk("stall_addr", 32'(mem_addr_o), 32'h0F8);
            chk("stall_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        chk("stall_req6", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        tick();
        mem_rvalid_i = 1'b0;
        chk("stall_rsp", 32'(rsp_valid_o), 32'd1);
        chk("stall_rdata", rdata_o, 32'h12345678);
        tick();

        // Reset while waiting for read data.
        req_valid_i = 1'b1; rw_ctrl_i = 4'b0010; addr_i = 32'h010;
        mem_gnt_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        mem_gnt_i = 1'b0;
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFECAFE;
        chk("wrst_ready", 32'(req_ready_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0;
        chk("wrst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("wrst_ready2", 32'(req_ready_o), 32'd1);
        chk("wrst_req", 32'(mem_req_o), 32'd0);
        chk("wrst_rdata", rdata_o, 32'd0);
        tick();
        chk("wrst_rsp2", 32'(rsp_valid_o), 32'd0);

        // Back-to-back: sw then lhu held valid through the bubble.
        req_valid_i = 1'b1; rw_ctrl_i = 4'b1010; addr_i = 32'h004;
        wdata_i = 32'hCAFEF00D; mem_gnt_i = 1'b1;
        tick();
        rw_ctrl_i = 4'b0100; addr_i = 32'h006;
        chk("b2b_sw_be", 32'(mem_be_o), 32'hF);
        chk("b2b_sw_wd", mem_wdata_o, 32'hCAFEF00D);
        chk("b2b_ready0", 32'(req_ready_o), 32'd0);
        tick();
        chk("b2b_sw_rsp", 32'(rsp_valid_o), 32'd1);
        chk("b2b_ready1", 32'(req_ready_o), 32'd0);
        chk("b2b_rdata_hold", rdata_o, 32'd0);
        tick();
        chk("b2b_bubble_rsp", 32'(rsp_valid_o), 32'd0);
        chk("b2b_bubble_ready", 32'(req_ready_o), 32'd1);
        chk("b2b_bubble_req", 32'(mem_req_o), 32'd0);
        tick();
        req_valid_i = 1'b0;
        chk("b2b_lhu_req", 32'(mem_req_o), 32'd1);
        chk("b2b_lhu_we", 32'(mem_we_o), 32'd0);
        chk("b2b_lhu_be", 32'(mem_be_o), 32'hC);
        chk("b2b_lhu_addr", 32'(mem_addr_o), 32'h004);
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBEEF0000;
        tick();
        mem_rvalid_i = 1'b0;
        chk("b2b_lhu_rsp", 32'(rsp_valid_o), 32'd1);
        chk("b2b_lhu_rdata", rdata_o, 32'h0000BEEF);
        tick();
        chk("b2b_end_rsp", 32'(rsp_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter ADDR_W, default 12: data memory byte-address width; legal range 4..32.
REQ-002 Parameter DATA_W, fixed 32: bus data width; byte enables are DATA_W/8 = 4 bits.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rstn_i  in  1  reset, synchronous, active-low.
REQ-005 req_valid_i  in  1  core presents an access.
REQ-006 req_ready_o  out  1  unit accepts an access; high only in IDLE.
REQ-007 rw_ctrl_i  in  4  [3]=1 store, 0 load; [2:0]: 000 b, 001 h, 010 w, 011 bu, 100 hu.
REQ-008 addr_i  in  32  byte address from ALU.
REQ-009 wdata_i  in  32  store data from regfile.
REQ-010 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-011 rdata_o  out  32  aligned, extended load result; valid with rsp_valid_o on loads.
REQ-012 misalign_o  out  1  with rsp_valid_o: access aborted, misaligned.
REQ-013 illegal_o  out  1  with rsp_valid_o: access aborted, illegal rw_ctrl_i.
REQ-014 mem_req_o  out  1  memory request, held until granted.
REQ-015 mem_we_o  out  1  1 write, 0 read.
REQ-016 mem_be_o  out  4  byte enables.
REQ-017 mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 00.
REQ-018 mem_wdata_o  out  32  lane-positioned store data.
REQ-019 mem_gnt_i  in  1  memory accepts request this cycle.
REQ-020 mem_rvalid_i  in  1  read data valid this cycle.
REQ-021 mem_rdata_i  in  32  read data word.

Function
REQ-022 Accept = req_valid_i & req_ready_o; rw_ctrl_i, addr_i, wdata_i registered at accept.
REQ-023 FSM states IDLE, REQ, WAIT, RESP; all outputs except req_ready_o registered.
REQ-024 IDLE: legal aligned accept -> REQ; misaligned or illegal accept -> RESP with no memory request.
REQ-025 REQ: mem_req_o=1, address/be/we/wdata stable; on mem_gnt_i: store -> RESP, load -> WAIT.
REQ-026 WAIT: on mem_rvalid_i capture extended data -> RESP; mem_rvalid_i in REQ or IDLE ignored.
REQ-027 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; minimum one-cycle bubble between accesses.
REQ-028 Min latency accept-to-rsp_valid_o: store 2 cycles, load 3 cycles (gnt in first REQ cycle, rvalid next).
REQ-029 Illegal: store with [2:0] not in {000,001,010}; any [2:0] in {101,110,111}; illegal takes priority over misalign.
REQ-030 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00; byte never misaligned.
REQ-031 Byte enables: b = 0001<<addr[1:0]; h = 0011<<{addr[1],0}; w = 1111.
REQ-032 Store data: byte replicated to all 4 lanes; halfword replicated to both halves; word unchanged.
REQ-033 Load: select lane by addr[1:0]; lb/lh sign-extend from bit 7/15 of the selected field; lbu/lhu zero-extend.
REQ-034 rdata_o holds last load value until next load completes; misalign_o/illegal_o low when rsp_valid_o low.
REQ-035 mem_addr_o = addr[ADDR_W-1:2] with 00 appended; address bits above ADDR_W discarded without error.

Reset
REQ-036 rstn_i low at a clock edge: state IDLE; mem_req_o, mem_we_o, rsp_valid_o, misalign_o, illegal_o = 0; mem_be_o = 0; rdata_o, mem_addr_o, mem_wdata_o = 0.
REQ-037 Reset during REQ/WAIT abandons the access: no rsp_valid_o; a later mem_rvalid_i is ignored.
REQ-038 req_ready_o = 1 in the first cycle after reset deasserts.

Structure
REQ-039 Package lsu_pkg holds rw_ctrl encodings, FSM state encoding and DATA_W.
REQ-040 Combinational sub-module lsu_align computes mem_be_o, store-lane data, load extension and error flags; lsu_bus holds the FSM and registers.

Verification
REQ-041 sb addr=0x003, wdata=0x000000A5, gnt immediate -> mem_be_o=1000, mem_wdata_o=0xA5A5A5A5, mem_addr_o=0x000, rsp_valid_o 2 cycles after accept.
REQ-042 lb addr=0x102, mem_rdata_i=0x00807F00, rvalid cycle after gnt -> rdata_o=0xFFFFFF80; lbu same -> 0x00000080.
REQ-043 lh addr=0x101 -> no mem_req_o, rsp_valid_o+misalign_o one pulse; rw_ctrl_i=1011 -> illegal_o=1, misalign_o=0.
REQ-044 lw with mem_gnt_i held low 5 cycles -> mem_req_o and address stable all 5 cycles, req_ready_o=0 throughout.
REQ-045 rstn_i low during WAIT, then mem_rvalid_i pulse -> no rsp_valid_o, state IDLE, req_ready_o=1.
REQ-046 Back-to-back sw 0x004 then lhu 0x006 (rdata 0xBEEF0000) -> second accepted only after RESP; rdata_o=0x0000BEEF.
